// File: rtl/handshake_fifo_responder_pkg.sv
// Shared defaults and width helpers for the handshake FIFO responder slice.
package handshake_fifo_responder_pkg;

    localparam int unsigned default_data_width    = 32;
    localparam int unsigned default_depth         = 16;
    localparam int unsigned default_initial_value = 0;

    // Occupancy update chosen each cycle from the push/serve pair.
    typedef enum logic [1:0] {
        count_hold,
        count_inc,
        count_dec
    } count_op_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a completely full FIFO is representable.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/handshake_fifo_responder_if.sv
// Push side, status flags and req/ack pull handshake of the FIFO responder.
interface handshake_fifo_responder_if
    import handshake_fifo_responder_pkg::*;
#(
    parameter int unsigned data_width = default_data_width,
    parameter int unsigned depth      = default_depth
);

    logic                             wr_en;
    logic [data_width-1:0]            wr_data;
    logic                             full;
    logic                             empty;
    logic [count_width(depth)-1:0]    count;
    logic                             overflow;
    logic                             req;
    logic                             ack;
    logic [data_width-1:0]            dout;

    // The master pushes words and pulls them back; the slave is the responder.
    modport master (
        output wr_en, wr_data, req,
        input  full, empty, count, overflow, ack, dout
    );

    modport slave (
        input  wr_en, wr_data, req,
        output full, empty, count, overflow, ack, dout
    );

endinterface

// File: rtl/handshake_fifo_responder_fifo_mem.sv
// Register-array storage: one synchronous write port, asynchronous read.
module fifo_mem
    import handshake_fifo_responder_pkg::*;
#(
    parameter int unsigned data_width = default_data_width,
    parameter int unsigned depth      = default_depth
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [ptr_width(depth)-1:0]   wr_addr,
    input  logic [data_width-1:0]         wr_data,
    input  logic [ptr_width(depth)-1:0]   rd_addr,
    output logic [data_width-1:0]         rd_data
);

    logic [data_width-1:0] mem [depth];

    // Contents are not reset; the control pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/handshake_fifo_responder.sv
// Responder end of the req/ack pull handshake, serving words from an internal FIFO.
module handshake_fifo_responder
    import handshake_fifo_responder_pkg::*;
#(
    parameter int unsigned           data_width    = default_data_width,
    parameter int unsigned           depth         = default_depth,
    parameter logic [data_width-1:0] initial_value = data_width'(default_initial_value)
) (
    input  logic                       clk,
    input  logic                       rst,
    handshake_fifo_responder_if.slave  bus
);

    localparam int unsigned pw = ptr_width(depth);
    localparam int unsigned cw = count_width(depth);
    localparam logic [cw-1:0] full_count = cw'(depth);

    logic [pw-1:0]         rd_ptr;
    logic [pw-1:0]         wr_ptr;
    logic [cw-1:0]         count_q;
    logic [cw-1:0]         count_next;
    logic                  full_q;
    logic                  empty_q;
    logic                  overflow_q;
    logic                  ack_q;
    logic [data_width-1:0] dout_q;
    logic [data_width-1:0] rd_data;
    logic                  push;
    logic                  serve;
    count_op_t             count_op;

    // Both decisions use registered flags, so a push never bypasses into a serve.
    assign push  = bus.wr_en & ~full_q;
    assign serve = bus.req & ~ack_q & ~empty_q;

    always_comb begin
        count_op = count_hold;
        if (push && !serve) begin
            count_op = count_inc;
        end else if (serve && !push) begin
            count_op = count_dec;
        end
    end

    always_comb begin
        count_next = count_q;
        case (count_op)
            count_inc: count_next = count_q + 1'b1;
            count_dec: count_next = count_q - 1'b1;
            default:   count_next = count_q;
        endcase
    end

    fifo_mem #(
        .data_width (data_width),
        .depth      (depth)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Flags are registered from the next-state count so they track it exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            ack_q      <= 1'b0;
            dout_q     <= initial_value;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (bus.wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            if (serve) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout_q <= rd_data;
            end
            ack_q   <= serve;
            count_q <= count_next;
            full_q  <= (count_next == full_count);
            empty_q <= (count_next == '0);
        end
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.ack      = ack_q;
    assign bus.dout     = dout_q;

endmodule

// File: tb/tb_handshake_fifo_responder.sv
// Directed bench for handshake_fifo_responder with hand-computed expectations.
module tb_handshake_fifo_responder;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    handshake_fifo_responder_if #(.data_width(32), .depth(16)) bus ();

    handshake_fifo_responder #(
        .data_width    (32),
        .depth         (16),
        .initial_value (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] data, input logic rq);
        bus.wr_en   = wr;
        bus.wr_data = data;
        bus.req     = rq;
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got;
        int sent;
        int gap;
        logic prev_ack;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);

        #2 rst = 1'b0;
        #1;
        checkOutput("rst_ack", bus.ack, 0);
        checkOutput("rst_dout", bus.dout, 0);
        checkOutput("rst_count", bus.count, 0);
        checkOutput("rst_empty", bus.empty, 1);
        checkOutput("rst_full", bus.full, 0);
        checkOutput("rst_overflow", bus.overflow, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Ordered pull: acks land on cycles 1, 3, 5 of a continuous req.
        applyStimulus(1'b1, 32'd1, 1'b0); tick();
        applyStimulus(1'b1, 32'd2, 1'b0); tick();
        applyStimulus(1'b1, 32'd3, 1'b0); tick();
        checkOutput("pull_count3", bus.count, 3);
        applyStimulus(1'b0, 32'd0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            checkOutput("pull_ack", bus.ack, (i == 1 || i == 3 || i == 5) ? 1 : 0);
            if (i == 1 || i == 3 || i == 5) begin
                checkOutput("pull_dout", bus.dout, (i + 1) / 2);
            end
        end
        checkOutput("pull_empty", bus.empty, 1);
        checkOutput("pull_dout_held", bus.dout, 3);
        applyStimulus(1'b0, 32'd0, 1'b0);
        tick();

        // Fill to 16 then one extra push that must be dropped.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 32'd100 + 32'(i), 1'b0);
            tick();
            if (i == 15) begin
                checkOutput("fill_full", bus.full, 1);
                checkOutput("fill_count", bus.count, 16);
                checkOutput("fill_no_ovf_yet", bus.overflow, 0);
            end
        end
        checkOutput("ovf_set", bus.overflow, 1);
        checkOutput("ovf_count", bus.count, 16);
        checkOutput("ovf_full", bus.full, 1);

        applyStimulus(1'b1, 32'd999, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("simul_ack", bus.ack, 1);
        checkOutput("simul_dout", bus.dout, 100);
        checkOutput("simul_count", bus.count, 15);
        checkOutput("simul_full", bus.full, 0);
        checkOutput("simul_overflow", bus.overflow, 1);

        got = 0;
        for (int c = 0; c < 60 && got < 15; c++) begin
            tick();
            if (bus.ack) begin
                checkOutput("drain_dout", bus.dout, 101 + got);
                got++;
            end
        end
        checkOutput("drain_got", got, 15);
        checkOutput("drain_empty", bus.empty, 1);
        checkOutput("drain_count", bus.count, 0);
        applyStimulus(1'b0, 32'd0, 1'b0);
        tick();

        // Requester waits on an empty FIFO, then a single push is served.
        applyStimulus(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("wait_no_ack", bus.ack, 0);
        end
        applyStimulus(1'b1, 32'hDEAD, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("wait_ack_not_yet", bus.ack, 0);
        checkOutput("wait_not_empty", bus.empty, 0);
        tick();
        checkOutput("wait_ack", bus.ack, 1);
        checkOutput("wait_dout", bus.dout, 32'hDEAD);
        applyStimulus(1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("wait_ack_drop", bus.ack, 0);

        // Streaming with random push gaps through several pointer wraps.
        got      = 0;
        sent     = 0;
        gap      = 0;
        prev_ack = 1'b0;
        for (int c = 0; c < 2000 && got < 40; c++) begin
            tick();
            if (bus.ack) begin
                checkOutput("wrap_dout", bus.dout, 1000 + got);
                checkOutput("wrap_double_ack", prev_ack, 0);
                got++;
                bus.req = 1'b0;
            end else begin
                bus.req = (got < 40);
            end
            prev_ack = bus.ack;
            if (sent < 40 && gap == 0 && !bus.full) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 32'd1000 + 32'(sent);
                sent++;
                gap = int'($urandom_range(0, 3));
            end else begin
                bus.wr_en = 1'b0;
                if (gap > 0) gap--;
            end
        end
        checkOutput("wrap_received", got, 40);
        applyStimulus(1'b0, 32'd0, 1'b0);
        tick();
        tick();
        checkOutput("wrap_idle_ack", bus.ack, 0);
        checkOutput("wrap_empty", bus.empty, 1);

        // Mid-operation reset with count 5 and an ack in flight.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'd200 + 32'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        tick();
        checkOutput("mid_pre_ack", bus.ack, 1);
        checkOutput("mid_pre_count", bus.count, 5);
        checkOutput("mid_pre_dout", bus.dout, 200);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_ack", bus.ack, 0);
        checkOutput("mid_rst_count", bus.count, 0);
        checkOutput("mid_rst_empty", bus.empty, 1);
        checkOutput("mid_rst_dout", bus.dout, 0);
        checkOutput("mid_rst_overflow", bus.overflow, 0);
        applyStimulus(1'b0, 32'd0, 1'b0);
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_rst_no_ack", bus.ack, 0);
        end
        applyStimulus(1'b0, 32'd0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
